// File: rtl/memory_model_pkg.sv
// Shared constants and helpers for the iomem behavioural memory model.
package memory_model_pkg;

  localparam logic [31:0] DefaultBaseAddr  = 32'h4000_0000;
  localparam int unsigned DefaultMemDepth  = 'h1000;
  localparam int unsigned DefaultRespDelay = 16;

  // Replicated to DATA_WIDTH to form the out-of-range read value.
  localparam logic ErrRdBit = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_resp_delay.sv
// Fixed-latency response tracker: a one-hot token walks a RESP_DELAY-bit shift register.
module mem_resp_delay #(
  parameter int unsigned RESP_DELAY = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic idle_o,
  output logic ready_o
);

  logic [RESP_DELAY-1:0] dly_q, dly_d;

  assign idle_o  = (dly_q == '0);
  assign ready_o = dly_q[RESP_DELAY-1];

  always_comb begin
    dly_d = {dly_q[RESP_DELAY-2:0], 1'b0};
    if (idle_o) begin
      dly_d = {{(RESP_DELAY-1){1'b0}}, valid_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dly_q <= '0;
    end else begin
      dly_q <= dly_d;
    end
  end

endmodule

// File: rtl/iomem_memory_model.sv
// Word-addressed behavioural memory with a fixed-latency ready pulse.
// Define MEMORY_MODEL_BOUNDS_CHECK_EN for range checking; otherwise the index wraps.
module iomem_memory_model
  import memory_model_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = ADDR_WIDTH'(DefaultBaseAddr),
  parameter int unsigned            MEM_DEPTH  = DefaultMemDepth,
  parameter int unsigned            RESP_DELAY = DefaultRespDelay
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic                  wr_enable_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rsp_ready_o,
  output logic                  err_o
);

  localparam int unsigned OffW = clog2(DATA_WIDTH / 8);
  localparam int unsigned IdxW = (clog2(MEM_DEPTH) > 0) ? clog2(MEM_DEPTH) : 1;

  reg [DATA_WIDTH-1:0] mem_r [0:MEM_DEPTH-1];

  logic                  idle;
  logic                  accept;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IdxW-1:0]       idx;
  logic                  unused_word_addr;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  mem_resp_delay #(
    .RESP_DELAY (RESP_DELAY)
  ) u_resp_delay (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (cmd_valid_i),
    .idle_o  (idle),
    .ready_o (rsp_ready_o)
  );

  assign accept           = idle & cmd_valid_i;
  assign offset           = cmd_addr_i - BASE_ADDR;
  assign word_addr        = offset >> OffW;
  assign idx              = word_addr[IdxW-1:0];
  assign unused_word_addr = ^word_addr;

`ifdef MEMORY_MODEL_BOUNDS_CHECK_EN
  logic err_q, err_d;

  assign in_range = (cmd_addr_i >= BASE_ADDR) && (word_addr < ADDR_WIDTH'(MEM_DEPTH));

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = ~in_range;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q & rsp_ready_o;

  always_ff @(posedge clk_i) begin
    if (accept && !in_range) begin
      $display("iomem_memory_model: warning, out-of-range %s at address %h",
               wr_enable_i ? "write" : "read", cmd_addr_i);
    end
  end
`else
  // Index wraps modulo MEM_DEPTH, so every address maps onto the array.
  assign in_range = 1'b1;
  assign err_o    = 1'b0;
`endif

  always_comb begin
    rd_data_d = rd_data_q;
    if (accept && !wr_enable_i) begin
      rd_data_d = in_range ? mem_r[idx] : {DATA_WIDTH{ErrRdBit}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  // Array has no reset so preloaded contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (accept && wr_enable_i && in_range) begin
      mem_r[idx] <= wr_data_i;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_iomem_memory_model.sv
// Directed bench for iomem_memory_model: vector table plus reset/busy corner sequences.
module tb_iomem_memory_model;

  logic        clk_i;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic [31:0] cmd_addr_i;
  logic        wr_enable_i;
  logic [31:0] wr_data_i;
  logic [31:0] rd_data_o;
  logic        rsp_ready_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int ExpLat = 15;  // ready seen after the 15th edge following the accept edge

  iomem_memory_model dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_addr_i  (cmd_addr_i),
    .wr_enable_i (wr_enable_i),
    .wr_data_i   (wr_data_i),
    .rd_data_o   (rd_data_o),
    .rsp_ready_o (rsp_ready_o),
    .err_o       (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         output int lat, output logic [31:0] rd, output logic err);
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    wr_enable_i = wr;
    cmd_addr_i  = addr;
    wr_data_i   = data;
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
    lat = -1;
    rd  = '0;
    err = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_i);
      #1;
      if (rsp_ready_o) begin
        lat = i;
        rd  = rd_data_o;
        err = err_o;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i);
      #1;
      if (rsp_ready_o) pulses++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          pulses;
    int          first;
    logic [31:0] rd;
    logic        err;

    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = '0;
    wr_enable_i = 1'b0;
    wr_data_i   = '0;

`ifdef MEMORY_MODEL_BOUNDS_CHECK_EN
    vecs[0] = '{1'b0, 32'h4000_0000, 32'h0,         32'h0000_0093, 1'b0};
    vecs[1] = '{1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 32'h0000_0093, 1'b0};
    vecs[2] = '{1'b0, 32'h4000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 32'h4000_3FFC, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b0, 32'h4000_3FFC, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[5] = '{1'b0, 32'h4000_0014, 32'h0,         32'h1234_5678, 1'b0};
    vecs[6] = '{1'b0, 32'h4000_4000, 32'h0,         32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{1'b1, 32'h4000_4004, 32'h1111_1111, 32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{1'b0, 32'h4000_0004, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[9] = '{1'b0, 32'h3FFF_FFFC, 32'h0,         32'hFFFF_FFFF, 1'b1};
`else
    vecs[0] = '{1'b0, 32'h4000_0000, 32'h0,         32'h0000_0093, 1'b0};
    vecs[1] = '{1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 32'h0000_0093, 1'b0};
    vecs[2] = '{1'b0, 32'h4000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 32'h4000_3FFC, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b0, 32'h4000_3FFC, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[5] = '{1'b0, 32'h4000_0014, 32'h0,         32'h1234_5678, 1'b0};
    vecs[6] = '{1'b0, 32'h4000_4000, 32'h0,         32'h0000_0093, 1'b0};
    vecs[7] = '{1'b1, 32'h4000_4004, 32'h1111_1111, 32'h0000_0093, 1'b0};
    vecs[8] = '{1'b0, 32'h4000_0004, 32'h0,         32'h1111_1111, 1'b0};
    vecs[9] = '{1'b0, 32'h3FFF_FFFC, 32'h0,         32'hCAFE_F00D, 1'b0};
`endif

    // Reset held for 20 cycles; array preloaded hierarchically.
    repeat (2) @(posedge clk_i);
    dut.mem_r[0] = 32'h0000_0093;
    dut.mem_r[1] = 32'hA5A5_A5A5;
    dut.mem_r[2] = 32'h2222_2222;
    dut.mem_r[5] = 32'h1234_5678;
    repeat (18) @(posedge clk_i);
    #1;
    check("reset ready", {31'b0, rsp_ready_o}, 32'h0);
    check("reset rd_data", rd_data_o, 32'h0);
    check("reset err", {31'b0, err_o}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    count_pulses(5, pulses);
    check("post-reset idle pulses", pulses, 0);
    check("post-reset rd_data", rd_data_o, 32'h0);

    for (int v = 0; v < 10; v++) begin
      run_cmd(vecs[v].wr, vecs[v].addr, vecs[v].wdata, lat, rd, err);
      check($sformatf("vec%0d latency", v), lat, ExpLat);
      check($sformatf("vec%0d rd_data", v), rd, vecs[v].exp_rd);
      check($sformatf("vec%0d err", v), {31'b0, err}, {31'b0, vecs[v].exp_err});
      @(posedge clk_i);
      #1;
      check($sformatf("vec%0d ready single cycle", v), {31'b0, rsp_ready_o}, 32'h0);
    end
    check("mem_r[4] written", dut.mem_r[4], 32'hDEAD_BEEF);
    check("mem_r[4095] written", dut.mem_r[4095], 32'hCAFE_F00D);

    // Busy ignore: write presented while a read is pending, then held into re-accept.
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    wr_enable_i = 1'b0;
    cmd_addr_i  = 32'h4000_0000;
    @(posedge clk_i);
    #1;
    wr_enable_i = 1'b1;
    cmd_addr_i  = 32'h4000_0008;
    wr_data_i   = 32'h5555_5555;
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk_i);
      #1;
      if (rsp_ready_o) begin
        pulses++;
        if (first < 0) begin
          first = i;
          rd    = rd_data_o;
        end
      end
    end
    check("busy pulses", pulses, 1);
    check("busy latency", first, ExpLat);
    check("busy rd_data", rd, 32'h0000_0093);
    check("busy write ignored", dut.mem_r[2], 32'h2222_2222);
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    check("re-accept write", dut.mem_r[2], 32'h5555_5555);
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_i);
      #1;
      if (rsp_ready_o && first < 0) first = i;
    end
    check("re-accept latency", first, ExpLat);
    check("re-accept rd_data held", rd_data_o, 32'h0000_0093);

    // Mid-transaction reset during a read.
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    wr_enable_i = 1'b0;
    cmd_addr_i  = 32'h4000_0010;
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    check("mid-reset ready", {31'b0, rsp_ready_o}, 32'h0);
    check("mid-reset rd_data", rd_data_o, 32'h0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    count_pulses(30, pulses);
    check("mid-reset no pulse", pulses, 0);
    check("mid-reset array intact", dut.mem_r[4], 32'hDEAD_BEEF);

    // Mid-transaction reset after a write: the write must persist.
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    wr_enable_i = 1'b1;
    cmd_addr_i  = 32'h4000_0018;
    wr_data_i   = 32'h7777_7777;
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    count_pulses(30, pulses);
    check("write-reset no pulse", pulses, 0);
    check("write-reset kept", dut.mem_r[6], 32'h7777_7777);
    run_cmd(1'b0, 32'h4000_0018, 32'h0, lat, rd, err);
    check("post-reset read latency", lat, ExpLat);
    check("post-reset read data", rd, 32'h7777_7777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iomem_memory_model.md
# iomem_memory_model

Behavioural word-addressed memory with a fixed-latency ready response. It serves as the instruction/data backing store on the `islemci` `iomem` bus in simulation. Its array is preloadable by `$readmemh` through the hierarchical name `mem_r`. Each accepted command gets one `rsp_ready_o` pulse `RESP_DELAY` cycles later.

## Interface
- `BASE_ADDR`, default `32'h4000_0000`: byte address of word 0.
- `MEM_DEPTH`, default `'h1000`: number of words.
- `DATA_WIDTH`, default 32: word width; must be a multiple of 8.
- `ADDR_WIDTH`, default 32: width of the command address.
- `RESP_DELAY`, default 16: cycles from accept to ready; must be at least 2.
- `clk_i`, in, 1: the single clock.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `cmd_valid_i`, in, 1: command request.
- `cmd_addr_i`, in, `ADDR_WIDTH`: byte address.
- `wr_enable_i`, in, 1: 1 = write, 0 = read.
- `wr_data_i`, in, `DATA_WIDTH`: write data.
- `rd_data_o`, out, `DATA_WIDTH`: read data.
- `rsp_ready_o`, out, 1: one-cycle completion pulse.
- `err_o`, out, 1: out-of-range flag, valid while `rsp_ready_o` is high.

## Operation
- Storage is `reg [DATA_WIDTH-1:0] mem_r [0:MEM_DEPTH-1]`.
  - Reset never clears the array, so preloaded contents survive reset.
- Word index = `(cmd_addr_i - BASE_ADDR) >> log2(DATA_WIDTH/8)`. Byte-offset bits are ignored.
- The latency tracker is a `RESP_DELAY`-bit shift register `dly_q`.
  - Idle means `dly_q == 0`.
  - When idle, the block shifts `cmd_valid_i` into bit 0.
  - When not idle, it shifts left and inserts 0.
  - `rsp_ready_o = dly_q[RESP_DELAY-1]`.
- A command is accepted on a rising edge where the tracker is idle and `cmd_valid_i=1`. Commands presented while busy are ignored.
- Accepted write: `mem_r[idx] <= wr_data_i` at the accept edge, once. `rd_data_o` is unchanged.
- Accepted read: `rd_data_o <= mem_r[idx]` at the accept edge. It holds until the next accepted read.
- Non-accepted edges change neither the memory nor `rd_data_o`.
- The master drops `cmd_valid_i` in the cycle `rsp_ready_o` is high. If `cmd_valid_i` is still high one cycle after the ready pulse, the block accepts it as a new command.

## Timing
- Reset values: `dly_q=0`, `rsp_ready_o=0`, `rd_data_o=0`, `err_o=0`.
- An accept at edge N makes `rsp_ready_o` high for exactly the cycle after edge N+`RESP_DELAY`-1. It is low after edge N+`RESP_DELAY`.
- The tracker is idle again after edge N+`RESP_DELAY`. The earliest next accept is at edge N+`RESP_DELAY`+1.
- Reset asserted mid-transaction clears `dly_q` immediately; no ready pulse follows. A write already performed at its accept edge stays in memory.
- Reads and writes have the same latency.

## Configuration
- `MEMORY_MODEL_BOUNDS_CHECK_EN` defined:
  - An index ≥ `MEM_DEPTH`, or an address below `BASE_ADDR`, is out of range.
  - Out-of-range writes are dropped.
  - Out-of-range reads return all-ones.
  - `err_o` is registered at accept and asserted together with `rsp_ready_o`.
  - An out-of-range accept emits a `$display` warning.
- Macro absent:
  - The index wraps modulo `MEM_DEPTH`; `MEM_DEPTH` must be a power of two.
  - `err_o` is tied to 0.

## Structure
- Package `memory_model_pkg` holds:
  - the default base-address, depth and delay constants;
  - a `clog2` helper function;
  - the all-ones error read value.
- Sub-module `mem_resp_delay` contains the `dly_q` shift-register tracker.
  - Ports: `clk_i`, `rst_ni`, `valid_i`, `idle_o`, `ready_o`.
  - The array and the data path stay in the top module.

## Test plan
- Reset check: hold `rst_ni=0` for 20 cycles, then release with `cmd_valid_i=0`.
  - `rsp_ready_o`, `rd_data_o` and `err_o` stay 0.
- Preload and read: `$readmemh` sets `mem_r[0]=32'h00000093`, then read at `32'h4000_0000`.
  - Ready pulses 16 cycles after accept with `rd_data_o=32'h00000093`.
- Write then read: write `32'hDEADBEEF` to `32'h4000_0010`, then read `32'h4000_0013`.
  - `rd_data_o=32'hDEADBEEF`; `mem_r[4]` is updated.
- Busy ignore: during a pending read, change `cmd_addr_i` and assert a write.
  - Memory is unchanged; exactly one ready pulse occurs.
  - Holding valid high re-accepts one cycle after the pulse.
- Mid-transaction reset: assert `rst_ni=0` 5 cycles after a read accept.
  - No ready pulse follows; the array is intact.
- Bounds (macro defined): read `32'h4000_4000` with `MEM_DEPTH='h1000`.
  - `err_o=1` with ready and `rd_data_o=32'hFFFFFFFF`.
  - Without the macro, the same read returns `mem_r[0]` and `err_o=0`.
